fled_ws2812_tx: RTL and testbench
=================================

Name: fled_ws2812_tx

Overview:
- Avalon-ST sink that consumes 24-bit {R,G,B} LED colour words, such as those on the fled streams, and serialises them onto a single-wire WS2812-class LED chain.
- Each accepted word becomes one pixel, sent in G,R,B order, MSB first, with NRZ pulse-width bit encoding.
- After LED_COUNT pixels, the block drives a low latch/reset period so the chain displays the frame.
- One instance per fled channel, placed between a colour source and the board LED pin.

Parameters:
- T0H, 20, cycles high for a 0 bit (400 ns at 50 MHz)
- T0L, 42, cycles low for a 0 bit
- T1H, 40, cycles high for a 1 bit
- T1L, 22, cycles low for a 1 bit
- RST_CYCLES, 3000, latch low period (60 us at 50 MHz)
- LED_COUNT, 8, pixels per frame (1..255)

Ports:
- csi_MCLK_clk, in, 1: system clock
- rsi_MRST_reset, in, 1: asynchronous, active-high reset
- asi_fled_data, in, 24: pixel colour {R[23:16], G[15:8], B[7:0]}
- asi_fled_valid, in, 1: data valid
- asi_fled_ready, out, 1: sink ready (readyLatency 0)
- coe_led_dout, out, 1: serial line to the LED chain
- coe_frame_done, out, 1: one-cycle pulse when the latch period completes

Behaviour:
- Reset (async): coe_led_dout=0, asi_fled_ready=0, coe_frame_done=0, pixel_cnt=0, timer=0, state=LATCH. Reset asserted mid-bit drops dout to 0 immediately; the partial pixel is discarded.
- States: LATCH, IDLE, HIGH, LOW.
- LATCH:
  - dout=0, ready=0, timer counts 0..RST_CYCLES-1.
  - On the last count: frame_done=1 for one cycle, pixel_cnt<=0, go to IDLE.
- IDLE:
  - ready=1, dout=0.
  - On valid&&ready (cycle N): latch shift register <= {G,R,B} = {data[15:8], data[23:16], data[7:0]}, bit_idx<=23, timer<=0, go to HIGH.
  - dout rises at cycle N+1, a fixed latency of 1.
  - ready deasserts in the cycle after acceptance.
- HIGH:
  - dout=1 for T1H cycles if shreg[23]=1, else T0H cycles; then go to LOW with timer<=0.
- LOW, bit not last (bit_idx>0):
  - dout=0 for T1L or T0L cycles, matching the current bit.
  - Then shift left, bit_idx-1, go to HIGH.
- LOW, last bit (bit_idx==0):
  - After the low period, pixel_cnt+1.
  - If pixel_cnt+1==LED_COUNT: go to LATCH with timer<=0. Otherwise go to IDLE.
- Bit period: exactly T0H+T0L or T1H+T1L cycles (62 default).
- Last bit of each non-final pixel gains at least 1 extra low cycle, spent in IDLE.
- Upstream stall mid-frame (valid low in IDLE): dout held 0 indefinitely, no timeout. A stall of 50 us or longer latches the chain early; that is the source's responsibility.
- ready is never 1 outside IDLE, so data presented during HIGH/LOW/LATCH is held off by the handshake, not dropped.
- Counter widths: timer 16 bits; bit_idx 5 bits; pixel_cnt 8 bits. No wrap occurs within the legal parameter range.
- frame_done and ready are never asserted in the same cycle.

Test Plan:
- Release reset, valid held high with data 0x000000: ready stays 0 for 3000 cycles; frame_done pulses at cycle 3000; ready=1 on the next cycle.
- Single pixel 0xFF0000 (R=255): wire order G,R,B, so bits 0..7 are 20H/42L, bits 8..15 are 40H/22L, bits 16..23 are 20H/42L. Total 24*62 cycles; dout rises 1 cycle after acceptance.
- Back-to-back pixels with LED_COUNT=8 and data 0x123456 repeated: bench decodes 8 pixels each reading 0x123456 as R,G,B. Exactly 8 handshakes, then a 3000-cycle low and one frame_done pulse.
- Upstream stall: valid dropped for 500 cycles after pixel 3 → dout low for the whole gap, ready=1 throughout. Pixel 4 is accepted when valid returns; frame still completes after 8 pixels.
- Reset asserted at bit 10 of a pixel: dout=0 in the same cycle, ready=0. After release, a full 3000-cycle latch precedes the next accept, and pixel_cnt restarts at 0.
- Data presented while in HIGH/LATCH: ready=0, so no acceptance occurs until IDLE; the bench checks a handshake count equal to the pixels sent.

Source files
------------

// File: rtl/fled_ws2812_tx_if.sv
// fled_ws2812_tx_if
// Avalon-ST colour stream carrying one 24-bit {R,G,B} pixel per beat.
// The signal names follow the platform's Avalon naming so they map
// directly onto the fled stream ports.
//   asi_fled_data  : pixel colour {R[23:16], G[15:8], B[7:0]}
//   asi_fled_valid : source has a pixel on asi_fled_data
//   asi_fled_ready : sink can take the pixel this cycle (readyLatency 0)
// master = colour source, slave = LED transmitter.
interface fled_ws2812_tx_if;
  logic [23:0] asi_fled_data;
  logic        asi_fled_valid;
  logic        asi_fled_ready;

  modport master (
    output asi_fled_data,
    output asi_fled_valid,
    input  asi_fled_ready
  );

  modport slave (
    input  asi_fled_data,
    input  asi_fled_valid,
    output asi_fled_ready
  );
endinterface

// File: rtl/fled_ws2812_tx.sv
// fled_ws2812_tx
// Serialises 24-bit colour words onto a single-wire WS2812-class LED chain.
// Each accepted word is sent as one pixel in G,R,B order, MSB first, using
// NRZ pulse-width encoding. After LED_COUNT pixels the line is held low for
// RST_CYCLES so the chain latches the frame.
// Ports:
//   csi_MCLK_clk   : system clock
//   rsi_MRST_reset : asynchronous, active-high reset
//   fled           : Avalon-ST sink (data/valid/ready) for colour words
//   coe_led_dout   : serial line to the LED chain
//   coe_frame_done : one-cycle pulse when the latch period completes
// RST_CYCLES must be at least 2 and LED_COUNT in 1..255.
module fled_ws2812_tx #(
  parameter int T0H        = 20,
  parameter int T0L        = 42,
  parameter int T1H        = 40,
  parameter int T1L        = 22,
  parameter int RST_CYCLES = 3000,
  parameter int LED_COUNT  = 8
) (
  input  logic                   csi_MCLK_clk,
  input  logic                   rsi_MRST_reset,
  fled_ws2812_tx_if.slave        fled,
  output logic                   coe_led_dout,
  output logic                   coe_frame_done
);

  localparam logic [15:0] T0H_LAST = 16'(T0H - 1);
  localparam logic [15:0] T0L_LAST = 16'(T0L - 1);
  localparam logic [15:0] T1H_LAST = 16'(T1H - 1);
  localparam logic [15:0] T1L_LAST = 16'(T1L - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RST_PRE  = 16'(RST_CYCLES - 2);
  localparam logic [7:0]  PIX_LAST = 8'(LED_COUNT - 1);

  typedef enum logic [1:0] {
    S_LATCH,
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic [4:0]  bit_idx_q;
  logic [7:0]  pixel_cnt_q;
  logic [23:0] shreg_q;
  logic        dout_q;
  logic        ready_q;
  logic        done_q;

  logic [15:0] hi_last;
  logic [15:0] lo_last;
  logic        accept;
  logic        shift;

  // shreg_q[23] is the bit currently on the wire until the shift at the end
  // of its low phase, so both phase lengths key off it.
  assign hi_last = shreg_q[23] ? T1H_LAST : T0H_LAST;
  assign lo_last = shreg_q[23] ? T1L_LAST : T0L_LAST;

  // ready_q is high exactly while in IDLE, so this is the handshake.
  assign accept  = ready_q && fled.asi_fled_valid;
  assign shift   = (state_q == S_LOW) && (timer_q == lo_last) && (bit_idx_q != 5'd0);

  // Pixel data path: reloaded on every accept, so it needs no reset.
  always_ff @(posedge csi_MCLK_clk) begin
    if (accept) begin
      shreg_q <= {fled.asi_fled_data[15:8], fled.asi_fled_data[23:16], fled.asi_fled_data[7:0]};
    end else if (shift) begin
      shreg_q <= {shreg_q[22:0], 1'b0};
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q     <= S_LATCH;
      timer_q     <= 16'd0;
      bit_idx_q   <= 5'd0;
      pixel_cnt_q <= 8'd0;
      dout_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LATCH: begin
          timer_q <= timer_q + 16'd1;
          // The pulse register is loaded one count early so that the
          // pulse coincides with the final latch cycle; ready follows a
          // cycle later, keeping the two mutually exclusive.
          if (timer_q == RST_PRE) begin
            done_q <= 1'b1;
          end
          if (timer_q == RST_LAST) begin
            timer_q     <= 16'd0;
            pixel_cnt_q <= 8'd0;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            dout_q    <= 1'b1;
            bit_idx_q <= 5'd23;
            timer_q   <= 16'd0;
            state_q   <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (timer_q == hi_last) begin
            timer_q <= 16'd0;
            dout_q  <= 1'b0;
            state_q <= S_LOW;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_LOW: begin
          if (timer_q == lo_last) begin
            timer_q <= 16'd0;
            if (bit_idx_q != 5'd0) begin
              bit_idx_q <= bit_idx_q - 5'd1;
              dout_q    <= 1'b1;
              state_q   <= S_HIGH;
            end else begin
              pixel_cnt_q <= pixel_cnt_q + 8'd1;
              if (pixel_cnt_q == PIX_LAST) begin
                state_q <= S_LATCH;
              end else begin
                ready_q <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_LATCH;
          timer_q <= 16'd0;
        end
      endcase
    end
  end

  assign fled.asi_fled_ready = ready_q;
  assign coe_led_dout        = dout_q;
  assign coe_frame_done      = done_q;

endmodule

// File: tb/tb_fled_ws2812_tx.sv
// tb_fled_ws2812_tx
// Directed bench for fled_ws2812_tx: reset latch timing, a frame built from a
// table of pixels (with an upstream stall), decoding of the serial line back
// into wire words, mid-bit reset and a second frame after reset.
module tb_fled_ws2812_tx;
  localparam int T0H  = 20;
  localparam int T0L  = 42;
  localparam int T1H  = 40;
  localparam int T1L  = 22;
  localparam int RST  = 3000;
  localparam int NLED = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout;
  logic fdone;

  fled_ws2812_tx_if bus ();

  fled_ws2812_tx #(
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
    .RST_CYCLES(RST), .LED_COUNT(NLED)
  ) dut (
    .csi_MCLK_clk  (clk),
    .rsi_MRST_reset(rst),
    .fled          (bus),
    .coe_led_dout  (dout),
    .coe_frame_done(fdone)
  );

  always #10 clk = ~clk;

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // Line monitor: run lengths of high and low levels, sampled after each edge.
  int   cyc = 0;
  int   hq[$];
  int   lq[$];
  int   hrun = 0;
  int   lrun = 0;
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  int   last_fall = -1;
  int   hs = 0;
  logic dout_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (dout === 1'b1) begin
      if (!dout_prev) begin
        lq.push_back(lrun);
        hrun = 0;
      end
      hrun++;
    end else begin
      if (dout_prev) begin
        hq.push_back(hrun);
        lrun = 0;
        last_fall = cyc;
      end
      lrun++;
    end
    dout_prev = (dout === 1'b1);
    if (fdone === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (bus.asi_fled_valid && bus.asi_fled_ready === 1'b1) hs++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [23:0] data;
    logic [23:0] wire_exp;
    int          gap;
  } vec_t;

  vec_t tbl[NLED];

  // Present d and wait for it to be taken; check the one-cycle rise latency.
  task automatic send(input logic [23:0] d);
    bit ok = 1'b0;
    bus.asi_fled_data  = d;
    bus.asi_fled_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.asi_fled_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      step();
      chk("rise_latency_dout", int'(dout), 1);
      chk("ready_drop_after_accept", int'(bus.asi_fled_ready), 0);
    end
  endtask

  // Release reset and measure the latch period that follows.
  task automatic latch_check(input string tag);
    int first_fd  = -1;
    int first_rdy = -1;
    int hs0 = hs;
    int fd0 = fd_cnt;
    bus.asi_fled_data  = 24'h000000;
    bus.asi_fled_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= RST + 50; n++) begin
      step();
      if (fdone === 1'b1 && first_fd < 0) first_fd = n;
      if (bus.asi_fled_ready === 1'b1) begin
        first_rdy = n;
        bus.asi_fled_valid = 1'b0;
        break;
      end
    end
    chk({tag, "_frame_done_cycle"}, first_fd, RST - 1);
    chk({tag, "_ready_cycle"}, first_rdy, RST);
    chk({tag, "_no_accept_in_latch"}, hs - hs0, 0);
    chk({tag, "_frame_done_pulses"}, fd_cnt - fd0, 1);
  endtask

  // Send the table as one frame, then decode and check the line.
  task automatic run_frame(input string tag);
    int hs0 = hs;
    int fd0 = fd_cnt;
    int bad;
    int seen = 0;
    hq.delete();
    lq.delete();
    for (int p = 0; p < NLED; p++) begin
      if (tbl[p].gap > 0) begin
        bus.asi_fled_valid = 1'b0;
        for (int i = 0; i < 4000 && bus.asi_fled_ready !== 1'b1; i++) step();
        bad = 0;
        for (int i = 0; i < tbl[p].gap; i++) begin
          step();
          if (bus.asi_fled_ready !== 1'b1 || dout !== 1'b0) bad++;
        end
        chk({tag, "_stall_hold"}, bad, 0);
      end
      send(tbl[p].data);
    end
    // Keep data on the bus through the rest of the frame and the latch.
    bus.asi_fled_data  = 24'hABCDEF;
    bus.asi_fled_valid = 1'b1;
    for (int i = 0; i < 24 * 62 + RST + 200; i++) begin
      step();
      if (fd_cnt > fd0) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_frame_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_ready_low_at_done"}, int'(bus.asi_fled_ready), 0);
      chk({tag, "_latch_len"}, fd_cyc - last_fall, T0L + RST - 1);
      step();
      chk({tag, "_ready_after_done"}, int'(bus.asi_fled_ready), 1);
      chk({tag, "_done_one_cycle"}, int'(fdone), 0);
      bus.asi_fled_valid = 1'b0;
    end
    chk({tag, "_handshakes"}, hs - hs0, NLED);
    chk({tag, "_bit_count"}, hq.size(), NLED * 24);
    if (hq.size() == NLED * 24 && lq.size() >= NLED * 24) begin
      for (int p = 0; p < NLED; p++) begin
        int w = 0;
        bad = 0;
        for (int b = 0; b < 24; b++) begin
          int h = hq[p * 24 + b];
          int bv = (h == T1H) ? 1 : 0;
          int l;
          if (h != T1H && h != T0H) bad++;
          w = (w << 1) | bv;
          if (b < 23) begin
            l = lq[p * 24 + b + 1];
            if (l != (bv ? T1L : T0L)) bad++;
          end else if (p < NLED - 1) begin
            l = lq[p * 24 + 24];
            if (l < (bv ? T1L : T0L) + 1) bad++;
          end
        end
        chk($sformatf("%s_pixel%0d_word", tag, p), w, int'(tbl[p].wire_exp));
        chk($sformatf("%s_pixel%0d_timing", tag, p), bad, 0);
        if (tbl[p].gap > 0)
          chk_ge($sformatf("%s_pixel%0d_gap", tag, p), lq[p * 24], tbl[p].gap);
      end
    end
  endtask

  initial begin
    // Wire order is G,R,B: 0xFF0000 -> 0x00FF00, 0x123456 -> 0x341256.
    tbl[0] = '{24'hFF0000, 24'h00FF00, 0};
    for (int i = 1; i < NLED; i++) tbl[i] = '{24'h123456, 24'h341256, 0};
    tbl[3].gap = 500;

    bus.asi_fled_data  = 24'h000000;
    bus.asi_fled_valid = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_dout", int'(dout), 0);
    chk("reset_ready", int'(bus.asi_fled_ready), 0);
    chk("reset_frame_done", int'(fdone), 0);

    latch_check("boot");
    run_frame("frame1");

    // Reset in the high phase of bit 10 of an all-ones pixel.
    send(24'hFFFFFF);
    repeat (10 * 62 + 5) step();
    chk("midbit_dout_high_before_reset", int'(dout), 1);
    bus.asi_fled_data  = 24'h123456;
    bus.asi_fled_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("midbit_reset_dout", int'(dout), 0);
    chk("midbit_reset_ready", int'(bus.asi_fled_ready), 0);
    repeat (2) step();
    latch_check("after_reset");
    run_frame("frame2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
